// File: rtl/control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Fetch/decode/execute sequencer for the 8-bit microcontroller.
//             Drives every datapath load/select strobe and the memory write.
//  Revision : 1.0  initial release
// ============================================================================
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic [3:0] ALU_Sel,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write,
  output logic [4:0] state_dbg
);

  // Opcodes
  localparam logic [7:0] c_LDA_IMM = 8'h86, c_LDA_DIR = 8'h87;
  localparam logic [7:0] c_LDB_IMM = 8'h88, c_LDB_DIR = 8'h89;
  localparam logic [7:0] c_STA_DIR = 8'h96, c_STB_DIR = 8'h97;
  localparam logic [7:0] c_ADD = 8'h42, c_SUB = 8'h43, c_AND = 8'h44, c_OR = 8'h45;
  localparam logic [7:0] c_INCA = 8'h46, c_INCB = 8'h47, c_DECA = 8'h48, c_DECB = 8'h49;
  localparam logic [7:0] c_BRA = 8'h20, c_BMI = 8'h21, c_BPL = 8'h22, c_BEQ = 8'h23;
  localparam logic [7:0] c_BNE = 8'h24, c_BVS = 8'h25, c_BVC = 8'h26, c_BCS = 8'h27;
  localparam logic [7:0] c_BCC = 8'h28;

  // Bus selects
  localparam logic [1:0] c_B1_PC = 2'b00, c_B1_A = 2'b01, c_B1_B = 2'b10;
  localparam logic [1:0] c_B2_ALU = 2'b00, c_B2_BUS1 = 2'b01, c_B2_MEM = 2'b10;

  // Shared sequence states are disambiguated by IR in the next-state logic,
  // so that the strobes themselves depend on the state alone.
  typedef enum logic [4:0] {
    S_FETCH0 = 5'd0,  S_FETCH1 = 5'd1,  S_FETCH2 = 5'd2,  S_DECODE = 5'd3,
    S_OP0    = 5'd4,  S_OP1    = 5'd5,  S_LD2_A  = 5'd6,  S_LD2_B  = 5'd7,
    S_D2     = 5'd8,  S_D3     = 5'd9,  S_D4_A   = 5'd10, S_D4_B   = 5'd11,
    S_ST3_A  = 5'd12, S_ST3_B  = 5'd13, S_ADD    = 5'd14, S_SUB    = 5'd15,
    S_AND    = 5'd16, S_OR     = 5'd17, S_INCA   = 5'd18, S_DECA   = 5'd19,
    S_INCB   = 5'd20, S_DECB   = 5'd21, S_BR0    = 5'd22, S_BR1    = 5'd23,
    S_BR2    = 5'd24
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_taken;

  assign state_dbg = r_state;

  // State register; reset aborts any instruction in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH0;
    else        r_state <= w_next_state;
  end

  // Branch condition from the current flags {N,Z,V,C}
  always_comb begin
    w_taken = 1'b0;
    case (IR)
      c_BRA:   w_taken = 1'b1;
      c_BMI:   w_taken = CCR_Result[3];
      c_BPL:   w_taken = ~CCR_Result[3];
      c_BEQ:   w_taken = CCR_Result[2];
      c_BNE:   w_taken = ~CCR_Result[2];
      c_BVS:   w_taken = CCR_Result[1];
      c_BVC:   w_taken = ~CCR_Result[1];
      c_BCS:   w_taken = CCR_Result[0];
      c_BCC:   w_taken = ~CCR_Result[0];
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state sequencing
  always_comb begin
    w_next_state = S_FETCH0;
    case (r_state)
      S_FETCH0: w_next_state = S_FETCH1;
      S_FETCH1: w_next_state = S_FETCH2;
      S_FETCH2: w_next_state = S_DECODE;
      S_DECODE: begin
        case (IR)
          c_LDA_IMM, c_LDB_IMM, c_LDA_DIR, c_LDB_DIR,
          c_STA_DIR, c_STB_DIR:             w_next_state = S_OP0;
          c_ADD:                            w_next_state = S_ADD;
          c_SUB:                            w_next_state = S_SUB;
          c_AND:                            w_next_state = S_AND;
          c_OR:                             w_next_state = S_OR;
          c_INCA:                           w_next_state = S_INCA;
          c_DECA:                           w_next_state = S_DECA;
          c_INCB:                           w_next_state = S_INCB;
          c_DECB:                           w_next_state = S_DECB;
          c_BRA, c_BMI, c_BPL, c_BEQ, c_BNE,
          c_BVS, c_BVC, c_BCS, c_BCC:       w_next_state = S_BR0;
          default:                          w_next_state = S_FETCH0;
        endcase
      end
      S_OP0: w_next_state = S_OP1;
      S_OP1: begin
        case (IR)
          c_LDA_IMM:                                  w_next_state = S_LD2_A;
          c_LDB_IMM:                                  w_next_state = S_LD2_B;
          c_LDA_DIR, c_LDB_DIR, c_STA_DIR, c_STB_DIR: w_next_state = S_D2;
          default:                                    w_next_state = S_FETCH0;
        endcase
      end
      S_D2: begin
        case (IR)
          c_LDA_DIR, c_LDB_DIR: w_next_state = S_D3;
          c_STA_DIR:            w_next_state = S_ST3_A;
          c_STB_DIR:            w_next_state = S_ST3_B;
          default:              w_next_state = S_FETCH0;
        endcase
      end
      S_D3: begin
        case (IR)
          c_LDA_DIR: w_next_state = S_D4_A;
          c_LDB_DIR: w_next_state = S_D4_B;
          default:   w_next_state = S_FETCH0;
        endcase
      end
      S_BR0:   w_next_state = S_BR1;
      S_BR1:   w_next_state = S_BR2;
      default: w_next_state = S_FETCH0;
    endcase
  end

  // Strobe decode; everything is held low while reset is asserted
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    ALU_Sel  = 4'b0000;
    CCR_Load = 1'b0;
    Bus1_Sel = c_B1_PC;
    Bus2_Sel = c_B2_ALU;
    write    = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH0, S_OP0, S_BR0: begin
          Bus1_Sel = c_B1_PC;
          Bus2_Sel = c_B2_BUS1;
          MAR_Load = 1'b1;
        end
        S_FETCH1, S_OP1: PC_Inc = 1'b1;
        S_FETCH2: begin
          Bus2_Sel = c_B2_MEM;
          IR_Load  = 1'b1;
        end
        S_LD2_A, S_D4_A: begin
          Bus2_Sel = c_B2_MEM;
          A_Load   = 1'b1;
        end
        S_LD2_B, S_D4_B: begin
          Bus2_Sel = c_B2_MEM;
          B_Load   = 1'b1;
        end
        S_D2: begin
          Bus2_Sel = c_B2_MEM;
          MAR_Load = 1'b1;
        end
        S_ST3_A: begin
          Bus1_Sel = c_B1_A;
          write    = 1'b1;
        end
        S_ST3_B: begin
          Bus1_Sel = c_B1_B;
          write    = 1'b1;
        end
        S_ADD, S_SUB, S_AND, S_OR, S_INCA, S_DECA: begin
          Bus1_Sel = c_B1_A;
          Bus2_Sel = c_B2_ALU;
          A_Load   = 1'b1;
          CCR_Load = 1'b1;
          case (r_state)
            S_SUB:   ALU_Sel = 4'b0001;
            S_AND:   ALU_Sel = 4'b0010;
            S_OR:    ALU_Sel = 4'b0011;
            S_INCA:  ALU_Sel = 4'b0100;
            S_DECA:  ALU_Sel = 4'b0101;
            default: ALU_Sel = 4'b0000;
          endcase
        end
        S_INCB, S_DECB: begin
          Bus1_Sel = c_B1_B;
          Bus2_Sel = c_B2_ALU;
          B_Load   = 1'b1;
          CCR_Load = 1'b1;
          ALU_Sel  = (r_state == S_INCB) ? 4'b0100 : 4'b0101;
        end
        S_BR2: begin
          // Taken: datapath adds the fetched offset to the PC (operand address)
          if (w_taken) begin
            PC_Load  = 1'b1;
            Bus2_Sel = c_B2_MEM;
          end else begin
            PC_Inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Bench for control_unit with a behavioural datapath and memory.
//             Expected per-cycle strobe vectors are queued per instruction.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
  logic [3:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [4:0] state_dbg;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Behavioural datapath
  logic [7:0] pc, mar, ir, a, b, mem_q, bus1, bus2, alu_r;
  logic [3:0] ccr, alu_f;
  logic [8:0] alu_t;
  logic       alu_v, alu_c;
  logic [7:0] mem [256];

  assign IR = ir;
  assign CCR_Result = ccr;

  always_comb bus1 = (Bus1_Sel == 2'b01) ? a : (Bus1_Sel == 2'b10) ? b : pc;

  always_comb begin
    alu_t = 9'd0;
    alu_r = 8'd0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    case (ALU_Sel)
      4'b0000: begin
        alu_t = {1'b0, bus1} + {1'b0, b};
        alu_r = alu_t[7:0];
        alu_c = alu_t[8];
        alu_v = (bus1[7] == b[7]) && (alu_r[7] != bus1[7]);
      end
      4'b0001: begin
        alu_t = {1'b0, bus1} - {1'b0, b};
        alu_r = alu_t[7:0];
        alu_c = alu_t[8];
        alu_v = (bus1[7] != b[7]) && (alu_r[7] != bus1[7]);
      end
      4'b0010: alu_r = bus1 & b;
      4'b0011: alu_r = bus1 | b;
      4'b0100: begin
        alu_r = bus1 + 8'd1;
        alu_v = (bus1 == 8'h7F);
        alu_c = (bus1 == 8'hFF);
      end
      4'b0101: begin
        alu_r = bus1 - 8'd1;
        alu_v = (bus1 == 8'h80);
        alu_c = (bus1 == 8'h00);
      end
      default: ;
    endcase
    alu_f = {alu_r[7], alu_r == 8'd0, alu_v, alu_c};
  end

  always_comb bus2 = (Bus2_Sel == 2'b00) ? alu_r : (Bus2_Sel == 2'b01) ? bus1 : mem_q;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 8'd0; mar <= 8'd0; ir <= 8'd0; a <= 8'd0; b <= 8'd0; ccr <= 4'd0;
    end else begin
      if (IR_Load)  ir  <= bus2;
      if (MAR_Load) mar <= bus2;
      if (PC_Load)  pc  <= (Bus2_Sel == 2'b10) ? pc + mem_q : bus2;
      else if (PC_Inc) pc <= pc + 8'd1;
      if (A_Load)   a   <= bus2;
      if (B_Load)   b   <= bus2;
      if (CCR_Load) ccr <= alu_f;
    end
  end

  // Program image, then synchronous memory with one wait state
  initial begin
    logic [7:0] prog [32];
    prog = '{8'h86, 8'h5A, 8'h88, 8'h01, 8'h87, 8'h40, 8'h42, 8'h96,
             8'hF0, 8'h00, 8'h89, 8'h41, 8'h97, 8'hF1, 8'h00, 8'h43,
             8'h23, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h46, 8'h23,
             8'h05, 8'h48, 8'h47, 8'h49, 8'h45, 8'h44, 8'h21, 8'hDF};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = prog[i];
    mem[8'h40] = 8'h7F;
    mem[8'h41] = 8'h80;
    mem[8'hFE] = 8'h20;
    mem[8'hFF] = 8'h03;
    forever begin
      @(posedge clk);
      mem_q <= mem[mar];
      if (write) mem[mar] <= bus1;
    end
  end

  // Checking
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [15:0] ctl;
  assign ctl = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel,
                CCR_Load, Bus1_Sel, Bus2_Sel, write};

  // ld = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load}
  function automatic logic [15:0] cv(input logic [5:0] ld, input logic [3:0] alu,
                                     input logic ccrl, input logic [1:0] b1,
                                     input logic [1:0] b2, input logic wr);
    return {ld, alu, ccrl, b1, b2, wr};
  endfunction

  logic [15:0] sb_q [$];
  logic [15:0] exp_v;

  // Scoreboard: one expected strobe vector per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_v = sb_q.pop_front();
      check("strobes", ctl, exp_v);
      check("pc_load_and_inc", PC_Load & PC_Inc, 0);
      check("write_and_mar", write & MAR_Load, 0);
    end
  end

  task automatic push_instr(input logic [7:0] op, input logic tk);
    logic [15:0] opnd0;
    opnd0 = cv(6'b010000, 4'd0, 1'b0, 2'b00, 2'b01, 1'b0);
    sb_q.push_back(opnd0);                                          // FETCH0
    sb_q.push_back(cv(6'b000100, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));  // FETCH1
    sb_q.push_back(cv(6'b100000, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0));  // FETCH2
    sb_q.push_back(16'h0000);                                       // DECODE
    case (op)
      8'h86, 8'h88: begin
        sb_q.push_back(opnd0);
        sb_q.push_back(cv(6'b000100, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
        sb_q.push_back(cv({4'b0000, op == 8'h86, op == 8'h88}, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0));
      end
      8'h87, 8'h89: begin
        sb_q.push_back(opnd0);
        sb_q.push_back(cv(6'b000100, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
        sb_q.push_back(cv(6'b010000, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0));
        sb_q.push_back(16'h0000);
        sb_q.push_back(cv({4'b0000, op == 8'h87, op == 8'h89}, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0));
      end
      8'h96, 8'h97: begin
        sb_q.push_back(opnd0);
        sb_q.push_back(cv(6'b000100, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
        sb_q.push_back(cv(6'b010000, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0));
        sb_q.push_back(cv(6'b000000, 4'd0, 1'b0, (op == 8'h96) ? 2'b01 : 2'b10, 2'b00, 1'b1));
      end
      8'h42, 8'h43, 8'h44, 8'h45:
        sb_q.push_back(cv(6'b000010, op[3:0] - 4'd2, 1'b1, 2'b01, 2'b00, 1'b0));
      8'h46: sb_q.push_back(cv(6'b000010, 4'b0100, 1'b1, 2'b01, 2'b00, 1'b0));
      8'h48: sb_q.push_back(cv(6'b000010, 4'b0101, 1'b1, 2'b01, 2'b00, 1'b0));
      8'h47: sb_q.push_back(cv(6'b000001, 4'b0100, 1'b1, 2'b10, 2'b00, 1'b0));
      8'h49: sb_q.push_back(cv(6'b000001, 4'b0101, 1'b1, 2'b10, 2'b00, 1'b0));
      8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28: begin
        sb_q.push_back(opnd0);
        sb_q.push_back(16'h0000);
        if (tk) sb_q.push_back(cv(6'b001000, 4'd0, 1'b0, 2'b00, 2'b10, 1'b0));
        else    sb_q.push_back(cv(6'b000100, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
      end
      default: ;
    endcase
  endtask

  // Wait (bounded) until every queued vector has been compared
  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  // Run one instruction and stop just after its final edge has committed
  task automatic run(input logic [7:0] op, input logic tk);
    push_instr(op, tk);
    wait_drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobes", ctl, 0);
    check("reset_state", state_dbg, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run(8'h86, 1'b0); check("ldai_a", a, 8'h5A); check("ldai_pc", pc, 8'h02);
    run(8'h88, 1'b0); check("ldbi_b", b, 8'h01);
    run(8'h87, 1'b0); check("ldad_a", a, 8'h7F); check("ldad_pc", pc, 8'h06);
    run(8'h42, 1'b0); check("add_a", a, 8'h80); check("add_ccr", ccr, 4'b1010);
    run(8'h96, 1'b0); check("sta_mem", mem[8'hF0], 8'h80); check("sta_ccr", ccr, 4'b1010);
    check("sta_pc", pc, 8'h09);
    run(8'h00, 1'b0); check("nop_pc", pc, 8'h0A); check("nop_a", a, 8'h80);
    run(8'h89, 1'b0); check("ldbd_b", b, 8'h80);
    run(8'h97, 1'b0); check("stb_mem", mem[8'hF1], 8'h80);
    run(8'h00, 1'b0); check("nop2_pc", pc, 8'h0F);
    run(8'h43, 1'b0); check("sub_a", a, 8'h00); check("sub_ccr", ccr, 4'b0100);
    run(8'h23, 1'b1); check("beq_taken_pc", pc, 8'h16);
    run(8'h46, 1'b0); check("inca_a", a, 8'h01); check("inca_ccr", ccr, 4'b0000);
    run(8'h23, 1'b0); check("beq_not_taken_pc", pc, 8'h19);
    run(8'h48, 1'b0); check("deca_a", a, 8'h00);
    run(8'h47, 1'b0); check("incb_b", b, 8'h81);
    run(8'h49, 1'b0); check("decb_b", b, 8'h80);
    run(8'h45, 1'b0); check("or_a", a, 8'h80);
    run(8'h44, 1'b0); check("and_a", a, 8'h80);
    run(8'h21, 1'b1); check("bmi_pc", pc, 8'hFE);
    run(8'h20, 1'b1); check("bra_wrap_pc", pc, 8'h02);
    run(8'h88, 1'b0); check("ldbi2_b", b, 8'h01); check("ldbi2_pc", pc, 8'h04);

    // Abort LDA dir in its wait state
    push_instr(8'h87, 1'b0);
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    wait_drain();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_strobes", ctl, 0);
    check("abort_state", state_dbg, 0);
    @(posedge clk);
    #1;
    check("abort_hold_state", state_dbg, 0);
    reset = 1'b1;
    run(8'h86, 1'b0); check("refetch_a", a, 8'h5A); check("refetch_pc", pc, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
